// File: rtl/sme_pkg.sv
// Shared constants and types for the masked share encoder.
// A share word is one 32-bit slice of a Boolean-masked value.
package sme_pkg;

    localparam int SME_SMAX_DEFAULT = 3;
    localparam int SME_WORD_W       = 32;

    typedef logic [SME_WORD_W-1:0] sme_word_t;
    typedef sme_word_t sme_shares_t [SME_SMAX_DEFAULT];

endpackage

// File: rtl/sme_share_buf.sv
// Two-entry share FIFO that zeroises every slot it releases, so no stale
// shares are ever left behind after a pop, a flush or a reset.
module sme_share_buf
    import sme_pkg::*;
#(
    parameter int SMAX = SME_SMAX_DEFAULT
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    input  logic      i_flush,
    input  logic      i_push,
    input  sme_word_t i_data [SMAX],
    input  logic      i_pop,
    output logic      o_full,
    output logic      o_valid,
    output sme_word_t o_head [SMAX]
);

    localparam int DEPTH = 2;

    sme_word_t  r_mem [DEPTH][SMAX];
    logic       r_wptr;
    logic       r_rptr;
    logic [1:0] r_count;
    logic       w_push;
    logic       w_pop;

    assign o_full  = (r_count == 2'd2);
    assign o_valid = (r_count != 2'd0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & o_valid;

    always_comb begin
        for (int s = 0; s < SMAX; s++) begin
            o_head[s] = o_valid ? r_mem[r_rptr][s] : '0;
        end
    end

    // Push and pop never target the same slot: that would need an empty or full buffer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int e = 0; e < DEPTH; e++) begin
                for (int s = 0; s < SMAX; s++) begin
                    r_mem[e][s] <= '0;
                end
            end
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else if (i_flush) begin
            for (int e = 0; e < DEPTH; e++) begin
                for (int s = 0; s < SMAX; s++) begin
                    r_mem[e][s] <= '0;
                end
            end
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            for (int s = 0; s < SMAX; s++) begin
                if (w_push) r_mem[r_wptr][s] <= i_data[s];
                if (w_pop)  r_mem[r_rptr][s] <= '0;
            end
            if (w_push) r_wptr <= ~r_wptr;
            if (w_pop)  r_rptr <= ~r_rptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sme_share_encoder.sv
// Splits each plaintext word into SMAX Boolean shares using fresh random
// masks and buffers the shared words for the masked datapath.
module sme_share_encoder
    import sme_pkg::*;
#(
    parameter int SMAX = SME_SMAX_DEFAULT
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  sme_word_t   in_data,
    input  logic        rng_valid,
    input  sme_word_t   rng [SMAX-1],
    output logic        out_valid,
    input  logic        out_ready,
    output sme_word_t   out_data [SMAX],
    output logic [15:0] words_out
);

    logic        w_full;
    logic        w_push;
    logic        w_pop;
    sme_word_t   w_shares [SMAX];
    sme_word_t   w_mask_acc;
    logic [15:0] r_words_out;

    // A mask may only be used once, so acceptance is gated on a fresh rng word.
    assign in_ready  = g_resetn & rng_valid & ~w_full & ~flush;
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;
    assign words_out = r_words_out;

    always_comb begin
        for (int s = 0; s < SMAX; s++) begin
            w_shares[s] = '0;
        end
        w_mask_acc = in_data;
        for (int s = 0; s < SMAX - 1; s++) begin
            w_shares[s] = rng[s];
            w_mask_acc  = w_mask_acc ^ rng[s];
        end
        w_shares[SMAX-1] = w_mask_acc;
    end

    sme_share_buf #(
        .SMAX(SMAX)
    ) u_buf (
        .i_clk   (g_clk),
        .i_rst_n (g_resetn),
        .i_flush (flush),
        .i_push  (w_push),
        .i_data  (w_shares),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_valid (out_valid),
        .o_head  (out_data)
    );

    // A pop that coincides with a flush still counts as delivered.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_words_out <= 16'd0;
        end else if (w_pop) begin
            r_words_out <= r_words_out + 16'd1;
        end
    end

endmodule
